// File: rtl/cluster_bus_rd_scheduler.sv
// Round-robin scheduler sharing one AXI read port (AR/R) between NB_REQ requesters.
// The requester index is prefixed onto ARID and R beats are routed back by that prefix.
module cluster_bus_rd_scheduler #(
  parameter int unsigned NB_REQ            = 4,
  parameter int unsigned AXI_ADDR_WIDTH    = 64,
  parameter int unsigned AXI_DATA_WIDTH    = 64,
  parameter int unsigned AXI_ID_IN_WIDTH   = 4,
  parameter int unsigned MAX_OUTSTANDING   = 8,
  localparam int unsigned IDX_W            = $clog2(NB_REQ),
  localparam int unsigned AXI_ID_OUT_WIDTH = AXI_ID_IN_WIDTH + IDX_W,
  localparam int unsigned CNT_W            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  // Requester AR channels
  input  logic [NB_REQ-1:0]                    req_ar_valid_i,
  output logic [NB_REQ-1:0]                    req_ar_ready_o,
  input  logic [NB_REQ*AXI_ADDR_WIDTH-1:0]     req_ar_addr_i,
  input  logic [NB_REQ*8-1:0]                  req_ar_len_i,
  input  logic [NB_REQ*AXI_ID_IN_WIDTH-1:0]    req_ar_id_i,
  // Crossbar AR channel
  output logic                                 mst_ar_valid_o,
  input  logic                                 mst_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]            mst_ar_addr_o,
  output logic [7:0]                           mst_ar_len_o,
  output logic [AXI_ID_OUT_WIDTH-1:0]          mst_ar_id_o,
  // Crossbar R channel
  input  logic                                 mst_r_valid_i,
  output logic                                 mst_r_ready_o,
  input  logic [AXI_ID_OUT_WIDTH-1:0]          mst_r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]            mst_r_data_i,
  input  logic                                 mst_r_last_i,
  // Requester R channels
  output logic [NB_REQ-1:0]                    req_r_valid_o,
  input  logic [NB_REQ-1:0]                    req_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]            req_r_data_o,
  output logic [AXI_ID_IN_WIDTH-1:0]           req_r_id_o,
  output logic                                 req_r_last_o,
  // Status
  output logic                                 r_err_o,
  output logic                                 busy_o
);

  // ---------------------------------------------------------------------------
  // Unpack requester AR fields
  // ---------------------------------------------------------------------------
  logic [AXI_ADDR_WIDTH-1:0]  req_addr [NB_REQ];
  logic [7:0]                 req_len  [NB_REQ];
  logic [AXI_ID_IN_WIDTH-1:0] req_id   [NB_REQ];

  for (genvar i = 0; i < NB_REQ; i++) begin : g_unpack
    assign req_addr[i] = req_ar_addr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign req_len[i]  = req_ar_len_i[i*8 +: 8];
    assign req_id[i]   = req_ar_id_i[i*AXI_ID_IN_WIDTH +: AXI_ID_IN_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       ar_valid_q, ar_valid_d;
  logic [IDX_W-1:0]           ar_idx_q, ar_idx_d;
  logic [AXI_ID_IN_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [AXI_ADDR_WIDTH-1:0]  ar_addr_q, ar_addr_d;
  logic [7:0]                 ar_len_q, ar_len_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]           cnt_q [NB_REQ];
  logic [CNT_W-1:0]           cnt_d [NB_REQ];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NB_REQ-1:0] eligible;
  logic              arb_cycle;
  logic              gnt_found;
  logic              gnt;
  logic [IDX_W-1:0]  gnt_idx;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      eligible[i] = req_ar_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // First eligible requester scanning upwards from rr_ptr, wrapping at NB_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned o = 0; o < NB_REQ; o++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(o);
      if (cand >= (IDX_W+1)'(NB_REQ)) begin
        cand = cand - (IDX_W+1)'(NB_REQ);
      end
      if (!gnt_found && eligible[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign arb_cycle = !ar_valid_q || mst_ar_ready_i;
  assign gnt       = arb_cycle && gnt_found;

  always_comb begin
    req_ar_ready_o = '0;
    if (gnt) begin
      req_ar_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt) begin
      rr_ptr_d = (gnt_idx == IDX_W'(NB_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // AR buffer: a single entry, reloaded only on an arbitration cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_idx_d   = ar_idx_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    if (arb_cycle) begin
      ar_valid_d = gnt;
    end
    if (gnt) begin
      ar_idx_d  = gnt_idx;
      ar_id_d   = req_id[gnt_idx];
      ar_addr_d = req_addr[gnt_idx];
      ar_len_d  = req_len[gnt_idx];
    end
  end

  assign mst_ar_valid_o = ar_valid_q;
  assign mst_ar_addr_o  = ar_addr_q;
  assign mst_ar_len_o   = ar_len_q;
  assign mst_ar_id_o    = {ar_idx_q, ar_id_q};

  // ---------------------------------------------------------------------------
  // R routing
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      r_idx;
  logic [2**IDX_W-1:0]   idx_ok_map;
  logic                  r_idx_ok;
  logic                  r_last_hs;

  // Constant table of which index prefixes map to a real requester.
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_idx_map
    assign idx_ok_map[i] = (i < NB_REQ);
  end

  assign r_idx    = mst_r_id_i[AXI_ID_OUT_WIDTH-1 -: IDX_W];
  assign r_idx_ok = idx_ok_map[r_idx];

  always_comb begin
    req_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    if (r_idx_ok) begin
      req_r_valid_o[r_idx] = mst_r_valid_i;
      mst_r_ready_o        = req_r_ready_i[r_idx];
    end
  end

  assign r_err_o      = mst_r_valid_i && !r_idx_ok;
  assign req_r_data_o = mst_r_data_i;
  assign req_r_id_o   = mst_r_id_i[AXI_ID_IN_WIDTH-1:0];
  assign req_r_last_o = mst_r_last_i;
  assign r_last_hs    = mst_r_valid_i && mst_r_ready_o && mst_r_last_i;

  // ---------------------------------------------------------------------------
  // Outstanding-burst counters
  // ---------------------------------------------------------------------------
  logic [NB_REQ-1:0] cnt_inc;
  logic [NB_REQ-1:0] cnt_dec;
  logic [NB_REQ-1:0] cnt_nz;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    cnt_nz  = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cnt_nz[i]  = (cnt_q[i] != '0);
      cnt_inc[i] = gnt && (gnt_idx == IDX_W'(i));
      // A decrement on an empty counter is dropped rather than wrapping.
      cnt_dec[i] = r_last_hs && r_idx_ok && (r_idx == IDX_W'(i)) && cnt_nz[i];
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  assign busy_o = ar_valid_q || (|cnt_nz);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q <= 1'b0;
      ar_idx_q   <= '0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      rr_ptr_q   <= '0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_idx_q   <= ar_idx_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/cluster_bus_rd_scheduler.md
Name: cluster_bus_rd_scheduler

Overview:
- Shares one AXI read port (AR/R) of the cluster bus between NB_REQ requesters (cores, DMA, external), placed in front of one crossbar slave port.
- Round-robin arbitration on AR, with a per-requester outstanding-burst limit.
- Prefixes the requester index onto the ARID and routes R beats back by that prefix, the same ID-extension scheme the crossbar uses.

Parameters:
- NB_REQ, 4, number of requesters (≥2, need not be a power of 2)
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_ID_IN_WIDTH, 4, requester ID width
- MAX_OUTSTANDING, 8, max in-flight bursts per requester (≥1)
- Derived IDX_W = $clog2(NB_REQ); AXI_ID_OUT_WIDTH = AXI_ID_IN_WIDTH + IDX_W; CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_ar_valid_i  in  NB_REQ  per-requester AR valid
- req_ar_ready_o  out  NB_REQ  per-requester AR ready
- req_ar_addr_i  in  NB_REQ*AXI_ADDR_WIDTH  packed addresses
- req_ar_len_i  in  NB_REQ*8  packed burst lengths
- req_ar_id_i  in  NB_REQ*AXI_ID_IN_WIDTH  packed IDs
- mst_ar_valid_o  out  1  AR valid to crossbar
- mst_ar_ready_i  in  1  AR ready
- mst_ar_addr_o  out  AXI_ADDR_WIDTH  address
- mst_ar_len_o  out  8  burst length
- mst_ar_id_o  out  AXI_ID_OUT_WIDTH  {index, requester ID}
- mst_r_valid_i  in  1  R valid
- mst_r_ready_o  out  1  R ready
- mst_r_id_i  in  AXI_ID_OUT_WIDTH  R ID
- mst_r_data_i  in  AXI_DATA_WIDTH  R data
- mst_r_last_i  in  1  R last
- req_r_valid_o  out  NB_REQ  per-requester R valid
- req_r_ready_i  in  NB_REQ  per-requester R ready
- req_r_data_o  out  AXI_DATA_WIDTH  broadcast R data
- req_r_id_o  out  AXI_ID_IN_WIDTH  R ID with index stripped
- req_r_last_o  out  1  broadcast R last
- r_err_o  out  1  one-cycle pulse when an R beat with an invalid index is sunk
- busy_o  out  1  AR buffer full or any counter nonzero

Behaviour:

Reset:
- All outputs are 0 after reset, except the broadcast data, id and last fields, which are don't-care.
- rr_ptr=0, all counters=0, AR buffer empty.
- An asynchronous reset mid-burst drops all state; no R beat is forwarded until traffic resumes.

AR buffer:
- One registered entry. mst_ar_* are driven from this register only.
- Once valid, the entry stays stable until mst_ar_ready_i is high in the same cycle.

Arbitration:
- An arbitration cycle is a cycle where the buffer is empty, or valid&&mst_ar_ready_i.
- Eligible requester i: req_ar_valid_i[i] && cnt[i] < MAX_OUTSTANDING.
- Grant g = first eligible index scanning rr_ptr, rr_ptr+1, … mod NB_REQ.
- req_ar_ready_o[g] is high in that cycle (combinational); all other ready bits are low. No eligible requester means no grant and all ready bits low.
- On grant: the buffer loads {g, id_g}, addr_g, len_g. mst_ar_valid_o rises the next cycle, so latency is 1 cycle. rr_ptr <= (g+1) mod NB_REQ.
- rr_ptr holds when there is no grant.
- Back-to-back case: a buffer drain and a new grant in the same cycle give continuous valid, one AR per cycle.

Counters:
- cnt[g] increments on grant.
- cnt[k] decrements on mst_r_valid_i && mst_r_ready_o && mst_r_last_i, where k = mst_r_id_i[top IDX_W bits] and k<NB_REQ.
- Increment and decrement of the same counter in one cycle leaves it unchanged.
- A counter never exceeds MAX_OUTSTANDING and never underflows. A decrement at 0 is ignored.

R routing (combinational, zero latency):
- k<NB_REQ: req_r_valid_o[k]=mst_r_valid_i, other valid bits 0, mst_r_ready_o=req_r_ready_i[k].
- k≥NB_REQ (only possible when NB_REQ is not a power of 2): mst_r_ready_o=1, all req_r_valid_o=0, r_err_o=mst_r_valid_i.
- req_r_id_o = low AXI_ID_IN_WIDTH bits of mst_r_id_i.

Test Plan:
- Reset → all valids/readies 0, busy_o=0; assert rst_ni low mid-burst → cnt cleared, mst_ar_valid_o 0 the next cycle.
- All 4 requesters valid, mst_ar_ready_i=1 → grants 0,1,2,3,0 on consecutive cycles; mst_ar_id_o top bits match; one AR per cycle.
- Requester 2, id=4'h5, addr=64'h1000_0100, len=3 → next cycle mst_ar_id_o=6'h25; R beats with id 6'h25 reach req_r_valid_o[2] only, req_r_id_o=4'h5, cnt[2] back to 0 after the last beat.
- MAX_OUTSTANDING=2, requester 1 issues 2 ARs with no R returned → third request not granted while requester 3 is still granted; R last for idx 1 → requester 1 granted next arbitration.
- mst_ar_ready_i held 0 for 5 cycles → AR fields stable and no req_ar_ready_o asserted; same-cycle grant and R last to the same index → cnt unchanged.
- NB_REQ=3, R beat with idx=3 → mst_r_ready_o=1, r_err_o pulses 1 cycle, no req_r_valid_o asserted.
